// File: rtl/ws2812b_pixel_stream.sv
// WS2812B single-wire NRZ serialiser: shifts valid/ready pixel words out MSB-first
// and inserts the chain latch gap automatically whenever the stream runs dry.
module ws2812b_pixel_stream #(
  parameter int BIT_PERIOD_CLK_COUNTS  = 62,
  parameter int CODE_0_HIGH_CLK_COUNTS = 19,
  parameter int CODE_1_HIGH_CLK_COUNTS = 39,
  parameter int PIXEL_BITS             = 24,
  parameter int RESET_CLK_COUNTS       = 2500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic                  seq,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int STEP_W  = $clog2(BIT_PERIOD_CLK_COUNTS);
  localparam int BIT_W   = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam int LATCH_W = $clog2(RESET_CLK_COUNTS + 1);

  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(BIT_PERIOD_CLK_COUNTS - 1);
  localparam logic [STEP_W-1:0]  HIGH_0     = STEP_W'(CODE_0_HIGH_CLK_COUNTS);
  localparam logic [STEP_W-1:0]  HIGH_1     = STEP_W'(CODE_1_HIGH_CLK_COUNTS);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(PIXEL_BITS - 1);
  localparam logic [LATCH_W-1:0] LATCH_LAST = LATCH_W'(RESET_CLK_COUNTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  state_e                state_q, state_d;
  logic [PIXEL_BITS-1:0] shreg_q, shreg_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [LATCH_W-1:0]    latch_q, latch_d;
  logic                  seq_q, seq_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  last_cycle;
  logic                  accept;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    step_d       = step_q;
    bit_d        = bit_q;
    latch_d      = latch_q;
    last_cycle   = (state_q == ST_SHIFT) && (step_q == STEP_LAST) && (bit_q == BIT_LAST);
    // Held low during rst so the source never sees a handshake the reset will discard.
    pixel_ready  = !rst && ((state_q == ST_IDLE) || last_cycle);
    accept       = pixel_ready && pixel_valid;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = pixel_data;
          step_d  = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (accept) begin
              shreg_d = pixel_data;
            end else begin
              latch_d = '0;
              state_d = ST_LATCH;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q << 1;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (latch_q == LATCH_LAST) begin
          state_d = ST_IDLE;
        end else begin
          latch_d = latch_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from next-state values so the flops line up with the state they describe.
    seq_d        = (state_d == ST_SHIFT) &&
                   (step_d < (shreg_d[PIXEL_BITS-1] ? HIGH_1 : HIGH_0));
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_LATCH) && (latch_d == LATCH_LAST);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      step_q       <= '0;
      bit_q        <= '0;
      latch_q      <= '0;
      seq_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      step_q       <= step_d;
      bit_q        <= bit_d;
      latch_q      <= latch_d;
      seq_q        <= seq_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seq        = seq_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812b_pixel_stream.sv
// Bench for ws2812b_pixel_stream: a small-parameter instance for protocol scenarios and a
// default-parameter instance for full-size timing, both checked against an arithmetic waveform model.
module tb_ws2812b_pixel_stream;

  localparam int BP  = 8;
  localparam int C0  = 2;
  localparam int C1  = 5;
  localparam int PB  = 4;
  localparam int R   = 20;
  localparam int DBP = 62;
  localparam int DC0 = 19;
  localparam int DC1 = 39;
  localparam int DPB = 24;
  localparam int DR  = 2500;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, pixel_valid, pixel_ready, seq, busy, frame_done;
  logic [PB-1:0] pixel_data;
  logic          d_rst, d_valid, d_ready, d_seq, d_busy, d_frame_done;
  logic [DPB-1:0] d_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] tx_q[$];

  ws2812b_pixel_stream #(
    .BIT_PERIOD_CLK_COUNTS(BP), .CODE_0_HIGH_CLK_COUNTS(C0), .CODE_1_HIGH_CLK_COUNTS(C1),
    .PIXEL_BITS(PB), .RESET_CLK_COUNTS(R)
  ) dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .seq(seq), .busy(busy), .frame_done(frame_done)
  );

  ws2812b_pixel_stream dut_default (
    .clk(clk), .rst(d_rst), .pixel_data(d_data), .pixel_valid(d_valid),
    .pixel_ready(d_ready), .seq(d_seq), .busy(d_busy), .frame_done(d_frame_done)
  );

  // Line level at a given cycle offset into a word: bit = off/period, high while step < code time.
  function automatic logic exp_seq(input logic [31:0] word, input int off, input int bp,
                                   input int c0, input int c1, input int pb);
    int  k    = off / bp;
    int  step = off % bp;
    logic b   = word[pb-1-k];
    return (step < (b ? c1 : c0));
  endfunction

  // Streams tx_q from IDLE, checking {seq,busy,frame_done,pixel_ready} every cycle through the latch.
  task automatic stream_small(input string name, input bit hold_in_latch);
    int nw = tx_q.size();
    logic [3:0] exp_v, obs_v;
    @(negedge clk);
    pixel_valid = 1'b1;
    pixel_data  = tx_q[0][PB-1:0];
    n_checks++;
    if (pixel_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s idle_ready: got %b want 1", name, pixel_ready);
    end
    for (int i = 0; i < nw; i++) begin
      for (int off = 0; off < BP*PB; off++) begin
        @(negedge clk);
        obs_v = {seq, busy, frame_done, pixel_ready};
        exp_v = {exp_seq(tx_q[i], off, BP, C0, C1, PB), 1'b1, 1'b0, (off == BP*PB-1)};
        n_checks++;
        if (obs_v !== exp_v) begin
          n_fail++;
          $display("FAIL %s shift word%0d off%0d {seq,busy,fd,rdy}: got %b want %b",
                   name, i, off, obs_v, exp_v);
        end
        if (off == BP*PB-1) begin
          pixel_valid = (i + 1 < nw);
          pixel_data  = (i + 1 < nw) ? tx_q[i+1][PB-1:0] : PB'($urandom);
        end else begin
          // Random valid/data mid-pixel must not disturb the waveform.
          pixel_valid = 1'($urandom_range(0, 1));
          pixel_data  = PB'($urandom);
        end
      end
    end
    for (int l = 0; l < R; l++) begin
      @(negedge clk);
      obs_v = {seq, busy, frame_done, pixel_ready};
      exp_v = {1'b0, 1'b1, (l == R-1), 1'b0};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s latch cyc%0d {seq,busy,fd,rdy}: got %b want %b", name, l, obs_v, exp_v);
      end
      pixel_valid = hold_in_latch;
      pixel_data  = PB'($urandom);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    n_checks++;
    if ({seq, busy, frame_done, pixel_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL %s idle {seq,busy,fd,rdy}: got %b want 0001", name,
               {seq, busy, frame_done, pixel_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_rst = 1'b1; pixel_valid = 1'b1; d_valid = 1'b1;
    pixel_data = '1; d_data = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({seq, busy, frame_done, pixel_ready, d_seq, d_busy, d_frame_done, d_ready} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold outputs: got %b want 00000000",
               {seq, busy, frame_done, pixel_ready, d_seq, d_busy, d_frame_done, d_ready});
    end
    rst = 1'b0; d_rst = 1'b0; pixel_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({seq, busy, frame_done, pixel_ready, d_seq, d_busy, d_frame_done, d_ready} !== 8'b0001_0001) begin
      n_fail++;
      $display("FAIL reset_release outputs: got %b want 00010001",
               {seq, busy, frame_done, pixel_ready, d_seq, d_busy, d_frame_done, d_ready});
    end
  endtask

  task automatic test_single();
    tx_q = {32'hA};
    stream_small("single", 1'b0);
    check_idle("single");
  endtask

  task automatic test_back_to_back();
    tx_q = {32'hF, 32'h0};
    stream_small("b2b", 1'b0);
    check_idle("b2b");
  endtask

  task automatic test_latch_hold();
    tx_q = {32'($urandom_range(0, 15))};
    stream_small("hold", 1'b1);
    tx_q = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15))};
    stream_small("after_hold", 1'b0);
    check_idle("after_hold");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int nw = $urandom_range(1, 3);
      tx_q = {};
      for (int i = 0; i < nw; i++) tx_q.push_back(32'($urandom_range(0, 15)));
      stream_small($sformatf("rand%0d", n), 1'b0);
    end
    check_idle("rand_end");
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs_v;
    @(negedge clk);
    pixel_valid = 1'b1; pixel_data = 4'b0110;
    for (int off = 0; off <= 2*BP+2; off++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    obs_v = {seq, busy, frame_done, pixel_ready};
    if (obs_v !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_shift {seq,busy,fd,rdy}: got %b want 0000", obs_v);
    end
    rst = 1'b0;
    check_idle("rst_shift_release");
    pixel_valid = 1'b1; pixel_data = PB'($urandom);
    for (int c = 0; c < BP*PB + 10; c++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    obs_v = {seq, busy, frame_done, pixel_ready};
    if (obs_v !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_latch {seq,busy,fd,rdy}: got %b want 0000", obs_v);
    end
    rst = 1'b0;
    for (int c = 0; c < R + 4; c++) check_idle($sformatf("rst_latch_after%0d", c));
  endtask

  task automatic test_default_params();
    logic [31:0] word = 32'h80_0001;
    logic [2:0]  obs_v, exp_v;
    int          high_cnt;
    @(negedge clk);
    d_valid = 1'b1; d_data = word[DPB-1:0];
    n_checks++;
    if (d_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dflt idle_ready: got %b want 1", d_ready);
    end
    high_cnt = 0;
    for (int off = 0; off < DBP*DPB; off++) begin
      @(negedge clk);
      d_valid = 1'b0;
      obs_v = {d_seq, d_busy, d_ready};
      exp_v = {exp_seq(word, off, DBP, DC0, DC1, DPB), 1'b1, (off == DBP*DPB-1)};
      n_checks++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL dflt shift off%0d {seq,busy,rdy}: got %b want %b", off, obs_v, exp_v);
      end
      high_cnt += int'(d_seq);
      if (off % DBP == DBP-1) begin
        n_checks++;
        if (high_cnt != (word[DPB-1-off/DBP] ? DC1 : DC0)) begin
          n_fail++;
          $display("FAIL dflt bit%0d high_count: got %0d want %0d", off/DBP, high_cnt,
                   word[DPB-1-off/DBP] ? DC1 : DC0);
        end
        high_cnt = 0;
      end
    end
    for (int l = 0; l < DR; l++) begin
      @(negedge clk);
      n_checks++;
      if ({d_seq, d_busy, d_frame_done, d_ready} !== {1'b0, 1'b1, (l == DR-1), 1'b0}) begin
        n_fail++;
        $display("FAIL dflt latch cyc%0d {seq,busy,fd,rdy}: got %b want %b", l,
                 {d_seq, d_busy, d_frame_done, d_ready}, {1'b0, 1'b1, (l == DR-1), 1'b0});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({d_seq, d_busy, d_frame_done, d_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL dflt idle {seq,busy,fd,rdy}: got %b want 0001",
               {d_seq, d_busy, d_frame_done, d_ready});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_latch_hold();
    test_random();
    test_reset_mid();
    test_default_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
